gp_wb_arbiter: RTL
==================

Name: gp_wb_arbiter

Overview:
- Shares the single scalar write port of the GP-Core register file (R0-R7) between N_REQ writeback sources (default: ALU, MUL, LSU).
- Round-robin arbitration with a valid/ready handshake. The granted write is registered and driven to the register file one cycle later.
- Holds a per-register pending scoreboard: issue reserves a destination, writeback clears it. Issue logic uses this for RAW/WAW interlock.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8)
- DW, 32, scalar data width

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  N_REQ  writeback request per source
- req_ready  out  N_REQ  grant/accept per source (combinational)
- req_addr  in  N_REQ*3  destination register per source, source i at [3i+2:3i]
- req_data  in  N_REQ*DW  write data per source, source i at [DW*i+DW-1:DW*i]
- wb_stall  in  1  block all grants this cycle (debug halt, register file busy)
- scalar_we  out  1  register file write enable (registered)
- scalar_waddr  out  3  register file write address (registered)
- scalar_wdata  out  DW  register file write data (registered)
- rsv_valid  in  1  issue reserves a destination register
- rsv_addr  in  3  register being reserved
- busy  out  8  pending-write bit per register R0-R7 (registered)
- rsv_conflict  out  1  one-cycle pulse: reservation hit an already-busy register

Behaviour:
- Reset: clock and reset are one clock, with synchronous active-low reset (rst_n sampled on posedge clk). While rst_n=0 at a clock edge:
  - scalar_we=0, scalar_waddr=0, scalar_wdata=0
  - busy=8'h00, rsv_conflict=0
  - round-robin pointer=0 (source 0 highest priority)
  - req_ready is forced to 0 while rst_n=0
- Reset mid-operation: a grant made in the same cycle as reset is dropped. Nothing is written, and the requester must re-present.
- Arbitration (combinational):
  - Priority order starts at pointer p: p, p+1, ..., wrapping mod N_REQ.
  - The first source with req_valid=1 gets req_ready=1. At most one req_ready is high.
  - If wb_stall=1, all req_ready=0.
- Handshake rules:
  - A transfer occurs when req_valid[i]&req_ready[i].
  - A requester must hold valid, addr and data stable until accepted.
  - ready may depend on valid; valid must not depend on ready.
- Pointer update:
  - On a transfer from source g, p <= (g+1) mod N_REQ.
  - With no transfer, p is unchanged.
- Write timing, 1-cycle latency:
  - On the edge after a transfer, scalar_we=1 with the accepted addr and data.
  - If there is no transfer, scalar_we=0 and waddr/wdata hold their last values.
  - Throughput is one write per cycle; back-to-back grants produce back-to-back we.
- Scoreboard:
  - busy[scalar_waddr] clears on the edge ending a cycle with scalar_we=1, the same edge on which the register file writes.
  - busy[rsv_addr] sets on the edge ending a cycle with rsv_valid=1.
  - Reserve and clear of the same register in the same cycle: the reservation wins, so busy=1.
  - Reserve of a register whose busy=1 and is not being cleared this cycle: busy stays 1 and rsv_conflict=1 on the next cycle. This is a protocol violation that issue logic must avoid.
  - Reserve and clear of different registers in the same cycle: both take effect.
- Arithmetic: pointer wrap uses an explicit compare with N_REQ-1, with no reliance on power-of-two widths.

Optional Feature:
- Macro: GP_WB_PERF_EN.
- With the macro defined:
  - Extra output perf_conflict_cnt (16 bits) counts cycles where more than one req_valid is high and wb_stall=0.
  - Extra output perf_stall_cnt (16 bits) counts cycles where wb_stall=1 and any req_valid is high.
  - Both counters saturate at 16'hFFFF and reset to 0.
  - Extra input perf_clr (1 bit) clears both counters synchronously; a clear wins over an increment in the same cycle.
- Without the macro: these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
1. Reset, then source 1 valid with addr=3, data=32'hDEADBEEF -> req_ready=3'b010 in the same cycle. Next cycle: scalar_we=1, waddr=3, wdata=32'hDEADBEEF. The cycle after: we=0.
2. All 3 sources valid for 6 cycles, with data=i -> grant order 0,1,2,0,1,2. scalar_we is high for 6 consecutive cycles, starting 1 cycle after the first grant.
3. Source 0 valid while wb_stall=1 for 4 cycles -> req_ready=0 and scalar_we=0 throughout. After the stall drops, source 0 is accepted and written 1 cycle later.
4. rsv_valid with rsv_addr=5 -> busy=8'h20. Later, a writeback to R5 -> busy=8'h00 on the edge of scalar_we. In the same cycle as that writeback, rsv_addr=5 -> busy stays 8'h20 and rsv_conflict=0.
5. Reserve R2 twice without a writeback in between -> busy[2]=1 and rsv_conflict pulses for exactly 1 cycle.
6. Assert rst_n=0 in the same cycle as a grant to source 2 -> the next cycle shows scalar_we=0 and busy=0, and the pointer is 0 (source 0 wins the next contention). With GP_WB_PERF_EN defined, 3 contention cycles give perf_conflict_cnt=3, and perf_clr returns it to 0.

Source files
------------

// File: rtl/gp_wb_arbiter.sv
// gp_wb_arbiter
//   Shares the single scalar write port of the GP-Core register file (R0-R7)
//   between N_REQ writeback sources using round-robin arbitration. The
//   accepted write is registered and presented to the register file one
//   cycle later. An 8-entry pending scoreboard tracks reserved destinations
//   so issue logic can interlock on RAW/WAW hazards.
//
//   Ports:
//     clk, rst_n          core clock, synchronous active-low reset
//     req_valid/ready     per-source handshake (ready is combinational)
//     req_addr/req_data   per-source destination register and write data
//     wb_stall            blocks all grants this cycle
//     scalar_we/waddr/wdata  registered register-file write port
//     rsv_valid/rsv_addr  destination reservation from issue
//     busy                pending-write bit per register
//     rsv_conflict        pulse: reservation hit an already-busy register
//
//   Optional feature, enabled by defining GP_WB_PERF_EN:
//     perf_conflict_cnt   saturating count of multi-requester cycles (no stall)
//     perf_stall_cnt      saturating count of stalled cycles with a request
//     perf_clr            synchronous clear of both counters
module gp_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*3-1:0]  req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic                wb_stall,
    output logic                scalar_we,
    output logic [2:0]          scalar_waddr,
    output logic [DW-1:0]       scalar_wdata,
    input  logic                rsv_valid,
    input  logic [2:0]          rsv_addr,
    output logic [7:0]          busy,
`ifdef GP_WB_PERF_EN
    output logic [15:0]         perf_conflict_cnt,
    output logic [15:0]         perf_stall_cnt,
    input  logic                perf_clr,
`endif
    output logic                rsv_conflict
);

    localparam int              PW     = $clog2(N_REQ);
    localparam logic [PW:0]     NREQ_W = (PW+1)'(N_REQ);
    localparam logic [PW-1:0]   LAST   = PW'(N_REQ - 1);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          we_q;
    logic [2:0]    waddr_q;
    logic [DW-1:0] wdata_q;
    logic [7:0]    busy_q, busy_d;
    logic          conf_q, conf_d;

    logic [PW:0]   cand;
    logic [PW-1:0] grant_idx;
    logic          found;
    logic          transfer;
    logic [2:0]    sel_addr;
    logic [DW-1:0] sel_data;

    // Scan sources starting at the pointer; the one-bit-wider candidate
    // index lets the wrap be a plain compare against N_REQ.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && req_valid[cand[PW-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[PW-1:0];
            end
        end
        if (found && rst_n && !wb_stall) begin
            req_ready[grant_idx] = 1'b1;
        end
        transfer = |req_ready;
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == PW'(i)) begin
                sel_addr = req_addr[3*i +: 3];
                sel_data = req_data[DW*i +: DW];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (transfer) begin
            ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end
    end

    // Clear first, then set: a reservation landing on the register being
    // written back this cycle leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_addr] = 1'b1;
        end
        conf_d = rsv_valid && busy_q[rsv_addr] && !(we_q && (waddr_q == rsv_addr));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
            conf_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= transfer;
            busy_q <= busy_d;
            conf_q <= conf_d;
            if (transfer) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
            end
        end
    end

    assign scalar_we    = we_q;
    assign scalar_waddr = waddr_q;
    assign scalar_wdata = wdata_q;
    assign busy         = busy_q;
    assign rsv_conflict = conf_q;

`ifdef GP_WB_PERF_EN
    logic [15:0] pconf_q, pstall_q;
    logic        multi_req;
    logic        stall_req;

    assign multi_req = ($countones(req_valid) > 1) && !wb_stall;
    assign stall_req = wb_stall && (|req_valid);

    always_ff @(posedge clk) begin
        if (!rst_n || perf_clr) begin
            pconf_q  <= '0;
            pstall_q <= '0;
        end else begin
            if (multi_req && (pconf_q != 16'hFFFF)) begin
                pconf_q <= pconf_q + 16'd1;
            end
            if (stall_req && (pstall_q != 16'hFFFF)) begin
                pstall_q <= pstall_q + 16'd1;
            end
        end
    end

    assign perf_conflict_cnt = pconf_q;
    assign perf_stall_cnt    = pstall_q;
`endif

endmodule
